// File: rtl/as1802_bus_responder_if.sv
// Bus bundle between the AS1802 core (master) and its memory-side responder (slave).
// Multiplexed address, data in both directions, strobes, and the intr/EF return path.
interface as1802_bus_responder_if;
    logic [7:0] address;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       tpa;
    logic       mrd_n;
    logic       mwr_n;
    logic [1:0] sc;
    logic       q;
    logic       intr;
    logic [3:0] ef_n;

    modport master (
        output address, wdata, tpa, mrd_n, mwr_n, sc, q,
        input  rdata, intr, ef_n
    );

    modport slave (
        input  address, wdata, tpa, mrd_n, mwr_n, sc, q,
        output rdata, intr, ef_n
    );
endinterface

// File: rtl/as1802_bus_responder.sv
// AS1802 memory responder: flop RAM, interval timer, CTRL/EF registers in a 4-byte I/O window.
// Optional macro AS1802_RESP_AUTOACK_EN: entering interrupt service state (sc==2'b11) clears PEND.
module as1802_bus_responder #(
    parameter int          RAM_AW  = 10,
    parameter logic [15:0] IO_BASE = 16'hFFF0
) (
    input  logic                   clk,
    input  logic                   rst,
    as1802_bus_responder_if.slave  bus
);
    logic [7:0]  mem [2**RAM_AW];

    logic [7:0]  hi_lat_q, hi_lat_d;
    logic        mwr_prev_q;
    logic [15:0] rld_q, rld_d;
    logic [15:0] cnt_q, cnt_d;
    logic        en_q, en_d;
    logic        irq_en_q, irq_en_d;
    logic        pend_q, pend_d;
    logic [3:0]  efreg_q, efreg_d;
    logic        intr_q, intr_d;

    logic [15:0] addr;
    logic        in_ram;
    logic        in_io;
    logic        we;
    logic        wr_io;
    logic        ack;
    logic [7:0]  io_rdata;
    logic [7:0]  rdata_c;

    assign addr   = {hi_lat_q, bus.address};
    assign in_ram = (addr >> RAM_AW) == 16'd0;
    assign in_io  = addr[15:2] == IO_BASE[15:2];
    // One write per mwr_n pulse: commit only on the sampled high-to-low transition.
    assign we     = ~bus.mwr_n & mwr_prev_q;
    assign wr_io  = we & in_io;

`ifdef AS1802_RESP_AUTOACK_EN
    logic [1:0] sc_prev_q;
    assign ack = (bus.sc == 2'b11) && (sc_prev_q != 2'b11);
    always_ff @(posedge clk) begin
        if (rst) sc_prev_q <= 2'b00;
        else     sc_prev_q <= bus.sc;
    end
`else
    logic unused_sc;
    assign unused_sc = ^bus.sc;
    assign ack       = 1'b0;
`endif

    always_comb begin
        hi_lat_d = bus.tpa ? bus.address : hi_lat_q;
        rld_d    = rld_q;
        cnt_d    = cnt_q;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        pend_d   = pend_q;
        efreg_d  = efreg_q;
        intr_d   = pend_q & irq_en_q;

        if (wr_io) begin
            case (addr[1:0])
                2'd0: rld_d[7:0]  = bus.wdata;
                2'd1: rld_d[15:8] = bus.wdata;
                2'd2: begin
                    en_d     = bus.wdata[0];
                    irq_en_d = bus.wdata[1];
                    if (bus.wdata[2]) pend_d = 1'b0;
                end
                default: efreg_d = bus.wdata[3:0];
            endcase
        end
        if (ack) pend_d = 1'b0;

        // Underflow is evaluated last so it wins over any same-edge clear.
        if (en_q) begin
            if (cnt_q == 16'd0) begin
                cnt_d  = rld_q;
                pend_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end else if (wr_io && addr[1:0] == 2'd2 && bus.wdata[0]) begin
            cnt_d = rld_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_lat_q   <= 8'hFF;
            mwr_prev_q <= 1'b1;
            rld_q      <= 16'd0;
            cnt_q      <= 16'd0;
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            pend_q     <= 1'b0;
            efreg_q    <= 4'd0;
            intr_q     <= 1'b0;
        end else begin
            hi_lat_q   <= hi_lat_d;
            mwr_prev_q <= bus.mwr_n;
            rld_q      <= rld_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            pend_q     <= pend_d;
            efreg_q    <= efreg_d;
            intr_q     <= intr_d;
        end
    end

    // RAM has no reset; a write coinciding with rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && we && in_ram) mem[addr[RAM_AW-1:0]] <= bus.wdata;
    end

    always_comb begin
        case (addr[1:0])
            2'd0:    io_rdata = rld_q[7:0];
            2'd1:    io_rdata = rld_q[15:8];
            2'd2:    io_rdata = {5'd0, pend_q, irq_en_q, en_q};
            default: io_rdata = {3'd0, bus.q, efreg_q};
        endcase
    end

    // Unregistered: the core samples read data one edge after the low byte appears.
    always_comb begin
        rdata_c = 8'hFF;
        if (!bus.mrd_n) begin
            if (in_ram)     rdata_c = mem[addr[RAM_AW-1:0]];
            else if (in_io) rdata_c = io_rdata;
        end
    end

    assign bus.rdata = rdata_c;
    assign bus.intr  = intr_q;
    assign bus.ef_n  = ~efreg_q;
endmodule

// File: tb/tb_as1802_bus_responder.sv
// Directed bench for as1802_bus_responder; expectations depend on AS1802_RESP_AUTOACK_EN.
module tb_as1802_bus_responder;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    as1802_bus_responder_if bus_if ();

    as1802_bus_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_page(input logic [7:0] hi);
        bus_if.tpa     = 1'b1;
        bus_if.address = hi;
        cyc(1);
        bus_if.tpa     = 1'b0;
    endtask

    task automatic wr(input logic [7:0] lo, input logic [7:0] d);
        bus_if.address = lo;
        bus_if.wdata   = d;
        bus_if.mwr_n   = 1'b0;
        cyc(1);
        bus_if.mwr_n   = 1'b1;
        cyc(1);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] lo, input logic [7:0] exp);
        bus_if.address = lo;
        bus_if.mrd_n   = 1'b0;
        #1;
        check(tag, {8'd0, bus_if.rdata}, {8'd0, exp});
        bus_if.mrd_n   = 1'b1;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        bus_if.address = 8'h00;
        bus_if.wdata   = 8'h00;
        bus_if.tpa     = 1'b0;
        bus_if.mrd_n   = 1'b1;
        bus_if.mwr_n   = 1'b1;
        bus_if.sc      = 2'b00;
        bus_if.q       = 1'b0;
        cyc(3);
        rst = 1'b0;

        // Reset state; hi_lat resets to FF so the I/O window is reachable without TPA
        check("rst_intr", {15'd0, bus_if.intr}, 16'd0);
        check("rst_ef_n", {12'd0, bus_if.ef_n}, 16'h000F);
        check("idle_rdata", {8'd0, bus_if.rdata}, 16'h00FF);
        rd_chk("rst_rld_lo", 8'hF0, 8'h00);
        rd_chk("rst_ctrl", 8'hF2, 8'h00);
        rd_chk("rst_efreg", 8'hF3, 8'h00);

        // Basic write then read back without re-strobing TPA
        set_page(8'h02);
        wr(8'h34, 8'hA5);
        wr(8'h50, 8'h66);
        cyc(2);
        rd_chk("ram_0234", 8'h34, 8'hA5);
        bus_if.address = 8'h34;
        #1;
        check("mrd_hi_ff", {8'd0, bus_if.rdata}, 16'h00FF);

        // mwr_n held low 3 cycles: only the first data byte commits
        bus_if.address = 8'h40;
        bus_if.wdata   = 8'h11;
        bus_if.mwr_n   = 1'b0;
        cyc(1);
        bus_if.wdata   = 8'h22;
        cyc(2);
        bus_if.mwr_n   = 1'b1;
        cyc(1);
        rd_chk("held_low", 8'h40, 8'h11);

        // RAM boundaries and unmapped space
        set_page(8'h00);
        wr(8'h00, 8'h3C);
        set_page(8'h03);
        wr(8'hFF, 8'hC3);
        rd_chk("ram_top", 8'hFF, 8'hC3);
        set_page(8'h04);
        rd_chk("above_ram", 8'h00, 8'hFF);
        set_page(8'h80);
        rd_chk("unmapped_rd", 8'h00, 8'hFF);
        wr(8'h00, 8'h77);
        set_page(8'h00);
        rd_chk("no_alias_0", 8'h00, 8'h3C);
        set_page(8'h02);
        rd_chk("no_alias_234", 8'h34, 8'hA5);

        // Timer: reload 3 -> period 4
        set_page(8'hFF);
        wr(8'hF0, 8'h03);
        wr(8'hF1, 8'h00);
        rd_chk("rld_lo", 8'hF0, 8'h03);
        bus_if.address = 8'hF2;
        bus_if.wdata   = 8'h03;
        bus_if.mwr_n   = 1'b0;
        cyc(1);
        bus_if.mwr_n   = 1'b1;
        rd_chk("ctrl_en", 8'hF2, 8'h03);
        cyc(3);
        rd_chk("pend_e3", 8'hF2, 8'h03);
        cyc(1);
        rd_chk("pend_e4", 8'hF2, 8'h07);
        check("intr_e4", {15'd0, bus_if.intr}, 16'd0);
        cyc(1);
        check("intr_e5", {15'd0, bus_if.intr}, 16'd1);
        bus_if.wdata = 8'h07;
        bus_if.mwr_n = 1'b0;
        cyc(1);
        bus_if.mwr_n = 1'b1;
        rd_chk("pend_clr", 8'hF2, 8'h03);
        check("intr_e6", {15'd0, bus_if.intr}, 16'd1);
        cyc(1);
        check("intr_e7", {15'd0, bus_if.intr}, 16'd0);
        // Clear write lands on an underflow edge: set wins
        bus_if.wdata = 8'h04;
        bus_if.mwr_n = 1'b0;
        cyc(1);
        bus_if.mwr_n = 1'b1;
        rd_chk("set_wins", 8'hF2, 8'h04);
        cyc(1);
        check("intr_off", {15'd0, bus_if.intr}, 16'd0);
        wr(8'hF2, 8'h04);
        rd_chk("pend_clr2", 8'hF2, 8'h00);
        cyc(5);
        rd_chk("timer_off", 8'hF2, 8'h00);

        // EF register and Q readback
        wr(8'hF3, 8'h05);
        check("ef_n_05", {12'd0, bus_if.ef_n}, 16'h000A);
        bus_if.q = 1'b1;
        rd_chk("efreg_q1", 8'hF3, 8'h15);
        bus_if.q = 1'b0;
        wr(8'hF3, 8'hFF);
        rd_chk("efreg_mask", 8'hF3, 8'h0F);
        check("ef_n_ff", {12'd0, bus_if.ef_n}, 16'h0000);

        // PEND left set with the timer stopped, then enter interrupt service state
        wr(8'hF2, 8'h01);
        cyc(4);
        wr(8'hF2, 8'h00);
        rd_chk("pend_held", 8'hF2, 8'h04);
        bus_if.sc = 2'b11;
        cyc(1);
`ifdef AS1802_RESP_AUTOACK_EN
        rd_chk("autoack", 8'hF2, 8'h00);
`else
        rd_chk("no_autoack", 8'hF2, 8'h04);
`endif
        bus_if.sc = 2'b00;

        // Reset during a write edge discards the write and restores registers
        set_page(8'h02);
        bus_if.address = 8'h50;
        bus_if.wdata   = 8'h99;
        bus_if.mwr_n   = 1'b0;
        rst            = 1'b1;
        cyc(1);
        rst            = 1'b0;
        bus_if.mwr_n   = 1'b1;
        check("rst2_ef_n", {12'd0, bus_if.ef_n}, 16'h000F);
        rd_chk("rst2_ctrl", 8'hF2, 8'h00);
        set_page(8'h02);
        rd_chk("rst_drop_wr", 8'h50, 8'h66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
